syn_stdp_updater: RTL and testbench
===================================

// Module: syn_stdp_updater
// PURPOSE
//  STDP read-modify-write initiator for the synapse weight table (7-bit addr, 8-bit weights packed 4/word).
//  Accepts one update request (synapse addr, direction, spike-time difference) and reads the stored weight.
//  Computes a decayed, saturated delta and writes the weight back through the synapse W_EN/R_EN port.
//  Sits between the spike-timing logic and the synapse memory; the only runtime writer after init.
// PARAMETERS
//  ADDR_W   7    synapse address width (addr[6:2]=word, addr[1:0]=byte lane)
//  WEIGHT_W 8    weight width, unsigned
//  DT_W     8    spike-time difference width, unsigned ticks
//  RD_LAT   2    cycles from mem_ren strobe to valid mem_rdata (encoder reg + BRAM reg); >=1
//  A_PLUS   16   potentiation amplitude at dt=0
//  A_MINUS  12   depression amplitude at dt=0
//  TAU_SH   2    decay: delta = A >> min(dt>>TAU_SH, 7)
//  WINDOW   64   dt >= WINDOW -> no update
//  WMAX     255  upper weight clamp (lower clamp is 0)
// PORTS
//  clk        in   1        clock
//  rst        in   1        synchronous reset, active-low
//  req_valid  in   1        update request valid
//  req_ready  out  1        high only in IDLE; transfer on req_valid & req_ready
//  req_addr   in   ADDR_W   synapse index
//  req_pot    in   1        1=potentiate (+delta), 0=depress (-delta)
//  req_dt     in   DT_W     |t_post - t_pre|
//  mem_en     out  1        memory access strobe (one cycle per access)
//  mem_ren    out  1        read strobe, with mem_en
//  mem_wen    out  1        write strobe, with mem_en
//  mem_addr   out  ADDR_W   registered copy of req_addr, stable from accept to DONE
//  mem_wdata  out  32       new weight replicated in all four byte lanes
//  mem_rdata  in   WEIGHT_W addressed byte, valid RD_LAT cycles after read strobe
//  upd_done   out  1        one-cycle pulse per accepted request
//  upd_old    out  WEIGHT_W weight read (0 when skipped); valid with upd_done
//  upd_new    out  WEIGHT_W weight written/kept; valid with upd_done
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state=IDLE, all outputs 0 except req_ready=1; wait counter cleared.
//    Reset mid-operation aborts; a pending write is never issued. Strobes are single-cycle, so no partial access.
//  - FSM: IDLE -> RD -> WAIT -> CALC -> WR -> DONE -> IDLE.
//    IDLE: accept on valid&ready, latch addr/pot/dt.
//          If dt>=WINDOW, go directly to DONE (no memory access; upd_old=upd_new=0).
//    RD:   mem_en=mem_ren=1 for exactly one cycle.
//    WAIT: count RD_LAT cycles; sample mem_rdata on the last one into old_w.
//    CALC: shift = min(dt>>TAU_SH,7); delta = (pot?A_PLUS:A_MINUS)>>shift.
//          Compute in WEIGHT_W+2 signed: new = clamp(old_w±delta, 0, WMAX).
//    WR:   mem_en=mem_wen=1 for one cycle, mem_wdata={4{new}}. Skipped (CALC->DONE) when new==old_w.
//    DONE: upd_done=1 for one cycle; return to IDLE, where req_ready=1 next cycle.
//  - Latency accept->upd_done = RD_LAT+4 cycles (6 at default); accept->upd_done = 1 cycle when dt>=WINDOW.
//  - Never mem_ren & mem_wen together; one outstanding request; req_valid held during busy is ignored.
//  - Saturation: old=250, +16 -> 255 (WMAX); old=5, -12 -> 0.
// CONFIGURATION
//  SYN_STDP_STOCHASTIC_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1, reload on reset)
//    advances every cycle. In CALC, the update applies only if lfsr[7:0] < P_UPD (localparam 8'd128).
//    Otherwise new=old_w, no write, upd_done still pulses.
//  Not defined: deterministic, every in-window request applies; no LFSR logic.
// STRUCTURE
//  Shared package syn_pkg: ADDR_W, WEIGHT_W, DT_W constants; stdp_state_t enum (IDLE,RD,WAIT,CALC,WR,DONE);
//    weight_t typedef; clamp function.
//  Sub-module syn_stdp_lfsr (clk, rst, out[15:0]); instantiated only under SYN_STDP_STOCHASTIC_EN.
// TESTING (bench memory model: 32x32 byte-lane RAM, RD_LAT=2; deterministic unless noted)
//  1 weight[0x05]=100, req pot dt=0 -> read strobe cycle 1, write {4{8'd116}} to addr 5 at cycle 5, done cycle 6.
//  2 weight=100, depress dt=9 (shift 2) -> delta=3, new=97; upd_old=100, upd_new=97.
//  3 weight=250, pot dt=0 -> 255; weight=5, dep dt=0 -> 0; weight=255, pot -> no write strobe, done still pulses.
//  4 dt=64 -> no mem_en at all, done 1 cycle after accept, upd_new=0; back-to-back valid -> next accept after DONE.
//  5 rst low in WAIT -> next cycle IDLE, req_ready=1, no mem_wen ever seen, RAM unchanged.
//  6 SYN_STDP_STOCHASTIC_EN, 1000 pot dt=0 reqs on random addrs -> write count 450..550, matches reference LFSR model exactly.

Source files
------------

// File: rtl/syn_pkg.sv
// Shared types and constants for the STDP weight updater.
//   ADDR_W / WEIGHT_W / DT_W : synapse address, weight and spike-time-difference widths
//   stdp_state_t             : updater FSM states
//   weight_t / calc_t        : unsigned weight and the two-bit-wider signed working type
//   clamp()                  : saturate a signed working value into [0, wmax]
package syn_pkg;

  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned WEIGHT_W = 8;
  localparam int unsigned DT_W     = 8;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWait,
    StCalc,
    StWr,
    StDone
  } stdp_state_t;

  typedef logic        [WEIGHT_W-1:0] weight_t;
  typedef logic signed [WEIGHT_W+1:0] calc_t;

  function automatic weight_t clamp(input calc_t v, input int unsigned wmax);
    calc_t hi;
    hi = calc_t'(wmax);
    if (v < calc_t'(0)) begin
      return '0;
    end else if (v > hi) begin
      return hi[WEIGHT_W-1:0];
    end
    return v[WEIGHT_W-1:0];
  endfunction

endpackage

// File: rtl/syn_stdp_updater_if.sv
// Bundle of the updater's request, memory and completion signals.
//   req_*  : update request handshake (synapse index, direction, dt)
//   mem_*  : synapse memory port (single en strobe qualified by ren / wen)
//   upd_*  : completion pulse with the old and new weight
// Modports: master = the updater (drives the memory bus), slave = its environment.
interface syn_stdp_updater_if;

  logic                          req_valid;
  logic                          req_ready;
  logic [syn_pkg::ADDR_W-1:0]    req_addr;
  logic                          req_pot;
  logic [syn_pkg::DT_W-1:0]      req_dt;

  logic                          mem_en;
  logic                          mem_ren;
  logic                          mem_wen;
  logic [syn_pkg::ADDR_W-1:0]    mem_addr;
  logic [31:0]                   mem_wdata;
  logic [syn_pkg::WEIGHT_W-1:0]  mem_rdata;

  logic                          upd_done;
  logic [syn_pkg::WEIGHT_W-1:0]  upd_old;
  logic [syn_pkg::WEIGHT_W-1:0]  upd_new;

  modport master (
    input  req_valid, req_addr, req_pot, req_dt, mem_rdata,
    output req_ready, mem_en, mem_ren, mem_wen, mem_addr, mem_wdata,
    output upd_done, upd_old, upd_new
  );

  modport slave (
    output req_valid, req_addr, req_pot, req_dt, mem_rdata,
    input  req_ready, mem_en, mem_ren, mem_wen, mem_addr, mem_wdata,
    input  upd_done, upd_old, upd_new
  );

endinterface

// File: rtl/syn_stdp_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded with 16'hACE1 on reset and advancing
// every cycle. Only exists when SYN_STDP_STOCHASTIC_EN is defined.
//   clk : clock
//   rst : synchronous reset, active-low
//   out : current LFSR state
`ifdef SYN_STDP_STOCHASTIC_EN
module syn_stdp_lfsr (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] out
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      out <= 16'hACE1;
    end else begin
      out <= {out[14:0], out[15] ^ out[13] ^ out[12] ^ out[10]};
    end
  end

endmodule
`endif

// File: rtl/syn_stdp_updater.sv
// STDP read-modify-write initiator for the synapse weight table. Accepts one request,
// reads the addressed weight, applies a decayed and saturated delta, and writes it back
// (write skipped when the weight would not change). Requests with dt >= WINDOW complete
// one cycle after accept without touching memory.
//   clk : clock
//   rst : synchronous reset, active-low
//   bus : syn_stdp_updater_if.master (request, memory port, completion)
// Build option SYN_STDP_STOCHASTIC_EN: gate each in-window update on an LFSR draw
// (lfsr[7:0] < P_UPD); rejected draws keep the old weight but still complete.
module syn_stdp_updater
  import syn_pkg::*;
#(
  parameter int unsigned RD_LAT  = 2,
  parameter int unsigned A_PLUS  = 16,
  parameter int unsigned A_MINUS = 12,
  parameter int unsigned TAU_SH  = 2,
  parameter int unsigned WINDOW  = 64,
  parameter int unsigned WMAX    = 255
) (
  input logic                  clk,
  input logic                  rst,
  syn_stdp_updater_if.master   bus
);

  stdp_state_t       state_q;
  logic [7:0]        wait_cnt_q;
  logic              pot_q;
  logic [DT_W-1:0]   dt_q;
  weight_t           old_w_q;

  logic [DT_W-1:0]   dt_sh;
  logic [2:0]        shift;
  calc_t             amp;
  calc_t             delta;
  calc_t             sum;
  weight_t           new_w;
  logic              apply;

`ifdef SYN_STDP_STOCHASTIC_EN
  localparam logic [7:0] P_UPD = 8'd128;

  logic [15:0] lfsr;
  logic        unused_lfsr_hi;

  syn_stdp_lfsr u_lfsr (
    .clk (clk),
    .rst (rst),
    .out (lfsr)
  );

  assign apply          = (lfsr[7:0] < P_UPD);
  assign unused_lfsr_hi = ^lfsr[15:8];
`else
  assign apply = 1'b1;
`endif

  // Weight arithmetic runs two bits wider and signed so both overflow past WMAX and
  // underflow below zero are visible to the clamp.
  always_comb begin
    dt_sh = dt_q >> TAU_SH;
    shift = (dt_sh > DT_W'(7)) ? 3'd7 : dt_sh[2:0];
    amp   = pot_q ? calc_t'(A_PLUS) : calc_t'(A_MINUS);
    delta = amp >> shift;
    sum   = pot_q ? ($signed({2'b00, old_w_q}) + delta) : ($signed({2'b00, old_w_q}) - delta);
    new_w = apply ? clamp(sum, WMAX) : old_w_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      wait_cnt_q    <= '0;
      pot_q         <= 1'b0;
      dt_q          <= '0;
      old_w_q       <= '0;
      bus.req_ready <= 1'b1;
      bus.mem_en    <= 1'b0;
      bus.mem_ren   <= 1'b0;
      bus.mem_wen   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.upd_done  <= 1'b0;
      bus.upd_old   <= '0;
      bus.upd_new   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid && bus.req_ready) begin
            pot_q         <= bus.req_pot;
            dt_q          <= bus.req_dt;
            bus.mem_addr  <= bus.req_addr;
            bus.req_ready <= 1'b0;
            if (bus.req_dt >= DT_W'(WINDOW)) begin
              state_q      <= StDone;
              bus.upd_done <= 1'b1;
              bus.upd_old  <= '0;
              bus.upd_new  <= '0;
            end else begin
              state_q     <= StRd;
              bus.mem_en  <= 1'b1;
              bus.mem_ren <= 1'b1;
            end
          end
        end
        StRd: begin
          bus.mem_en  <= 1'b0;
          bus.mem_ren <= 1'b0;
          wait_cnt_q  <= '0;
          state_q     <= StWait;
        end
        StWait: begin
          // Read data is valid in the last of the RD_LAT wait cycles.
          if (wait_cnt_q == 8'(RD_LAT - 1)) begin
            old_w_q <= bus.mem_rdata;
            state_q <= StCalc;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        StCalc: begin
          bus.upd_old <= old_w_q;
          bus.upd_new <= new_w;
          if (new_w != old_w_q) begin
            state_q       <= StWr;
            bus.mem_en    <= 1'b1;
            bus.mem_wen   <= 1'b1;
            bus.mem_wdata <= {4{new_w}};
          end else begin
            state_q      <= StDone;
            bus.upd_done <= 1'b1;
          end
        end
        StWr: begin
          bus.mem_en   <= 1'b0;
          bus.mem_wen  <= 1'b0;
          bus.upd_done <= 1'b1;
          state_q      <= StDone;
        end
        StDone: begin
          bus.upd_done  <= 1'b0;
          bus.req_ready <= 1'b1;
          state_q       <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_syn_stdp_updater.sv
module tb_syn_stdp_updater;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  syn_stdp_updater_if bus ();

  syn_stdp_updater dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass   = 0;
  int n_checks = 0;

  // Memory model: 32 words x 4 byte lanes, read data valid 2 cycles after the strobe cycle.
  logic [31:0] ram [32];
  logic [7:0]  p1 = 8'd0;
  int          wen_total = 0;

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_ren) p1 <= ram[bus.mem_addr[6:2]][8*bus.mem_addr[1:0] +: 8];
    bus.mem_rdata <= p1;
    if (bus.mem_en && bus.mem_wen) begin
      ram[bus.mem_addr[6:2]][8*bus.mem_addr[1:0] +: 8] = bus.mem_wdata[8*bus.mem_addr[1:0] +: 8];
      wen_total++;
    end
  end

  // Reference LFSR, free-running from the same reset.
  logic [15:0] ref_lfsr = 16'hACE1;
  always @(posedge clk) begin
    if (!rst) ref_lfsr <= 16'hACE1;
    else ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
  end

  int both_strobes = 0;
  always @(negedge clk) if (bus.mem_ren && bus.mem_wen) both_strobes++;

  function automatic int get_w(input int a);
    logic [31:0] w;
    w = ram[a[6:2]];
    return int'(w[8*a[1:0] +: 8]);
  endfunction

  task automatic set_w(input int a, input int v);
    ram[a[6:2]][8*a[1:0] +: 8] = 8'(v);
  endtask

  // Spec rule: delta = A / 2^min(dt/4, 7), result clamped to [0, 255].
  function automatic int ref_new(input int old, input bit pot, input int dt);
    int sh, d, n;
    sh = dt / 4;
    if (sh > 7) sh = 7;
    d = (pot ? 16 : 12) / (1 << sh);
    n = pot ? old + d : old - d;
    if (n < 0) n = 0;
    if (n > 255) n = 255;
    return n;
  endfunction

  // Drives one request and traces it cycle by cycle (cycle 1 = first cycle after accept).
  task automatic issue(input int a, input bit pot, input int dt,
                       output int lat, output int rd_cyc, output int wr_cyc, output int en_cnt,
                       output logic [31:0] wdata, output int waddr, output int o_old,
                       output int o_new, output logic [15:0] lf);
    int guard;
    lat = -1; rd_cyc = -1; wr_cyc = -1; en_cnt = 0; wdata = '0; waddr = -1;
    o_old = -1; o_new = -1; lf = '0; guard = 0;
    @(negedge clk);
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) begin
      n_checks++;
      $display("FAIL ready_timeout: req_ready=%0b after 50 cycles, required 1", bus.req_ready);
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_addr  = 7'(a);
    bus.req_pot   = pot;
    bus.req_dt    = 8'(dt);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 4) lf = ref_lfsr;
      if (bus.mem_en) en_cnt++;
      if (bus.mem_en && bus.mem_ren) rd_cyc = c;
      if (bus.mem_en && bus.mem_wen) begin
        wr_cyc = c;
        wdata  = bus.mem_wdata;
        waddr  = int'(bus.mem_addr);
      end
      if (bus.upd_done) begin
        lat   = c;
        o_old = int'(bus.upd_old);
        o_new = int'(bus.upd_new);
        break;
      end
    end
  endtask

  int lat, rdc, wrc, enc, wa, uo, un;
  logic [31:0] wd;
  logic [15:0] lf;

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", bus.req_ready); else n_pass++;
    n_checks++; if (bus.mem_en !== 1'b0) $display("FAIL rst_mem_en: got %b want 0", bus.mem_en); else n_pass++;
    n_checks++; if (bus.upd_done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus.upd_done); else n_pass++;
    n_checks++; if ({bus.upd_old, bus.upd_new} !== 16'h0) $display("FAIL rst_upd: got %h want 0", {bus.upd_old, bus.upd_new}); else n_pass++;
    n_checks++; if (bus.mem_wdata !== 32'h0) $display("FAIL rst_wdata: got %h want 0", bus.mem_wdata); else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    set_w(5, 100);
    issue(5, 1'b1, 0, lat, rdc, wrc, enc, wd, wa, uo, un, lf);
    n_checks++; if (rdc != 1) $display("FAIL pot_rd_cycle: got %0d want 1", rdc); else n_pass++;
    n_checks++; if (wrc != 5) $display("FAIL pot_wr_cycle: got %0d want 5", wrc); else n_pass++;
    n_checks++; if (wd !== 32'h74747474) $display("FAIL pot_wdata: got %h want 74747474", wd); else n_pass++;
    n_checks++; if (wa != 5) $display("FAIL pot_waddr: got %0d want 5", wa); else n_pass++;
    n_checks++; if (lat != 6) $display("FAIL pot_latency: got %0d want 6", lat); else n_pass++;
    n_checks++; if (get_w(5) != 116) $display("FAIL pot_ram: got %0d want 116", get_w(5)); else n_pass++;
    set_w(18, 100);
    issue(18, 1'b0, 9, lat, rdc, wrc, enc, wd, wa, uo, un, lf);
    n_checks++; if (uo != 100 || un != 97) $display("FAIL dep_dt9: got old=%0d new=%0d want 100/97", uo, un); else n_pass++;
    n_checks++; if (get_w(18) != 97) $display("FAIL dep_dt9_ram: got %0d want 97", get_w(18)); else n_pass++;
  endtask

  task automatic test_saturation();
    set_w(33, 250);
    issue(33, 1'b1, 0, lat, rdc, wrc, enc, wd, wa, uo, un, lf);
    n_checks++; if (un != 255 || get_w(33) != 255) $display("FAIL sat_hi: got upd=%0d ram=%0d want 255", un, get_w(33)); else n_pass++;
    set_w(34, 5);
    issue(34, 1'b0, 0, lat, rdc, wrc, enc, wd, wa, uo, un, lf);
    n_checks++; if (un != 0 || get_w(34) != 0) $display("FAIL sat_lo: got upd=%0d ram=%0d want 0", un, get_w(34)); else n_pass++;
    set_w(35, 255);
    issue(35, 1'b1, 0, lat, rdc, wrc, enc, wd, wa, uo, un, lf);
    n_checks++; if (wrc != -1) $display("FAIL nochange_write: got write at cycle %0d want none", wrc); else n_pass++;
    n_checks++; if (lat != 5 || un != 255) $display("FAIL nochange_done: got lat=%0d new=%0d want 5/255", lat, un); else n_pass++;
  endtask

  task automatic test_window();
    set_w(40, 77);
    issue(40, 1'b1, 64, lat, rdc, wrc, enc, wd, wa, uo, un, lf);
    n_checks++; if (enc != 0) $display("FAIL window_mem_en: got %0d strobe cycles want 0", enc); else n_pass++;
    n_checks++; if (lat != 1) $display("FAIL window_latency: got %0d want 1", lat); else n_pass++;
    n_checks++; if (uo != 0 || un != 0) $display("FAIL window_upd: got old=%0d new=%0d want 0/0", uo, un); else n_pass++;
    n_checks++; if (get_w(40) != 77) $display("FAIL window_ram: got %0d want 77", get_w(40)); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int dones, last;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 7'd41; bus.req_pot = 1'b1; bus.req_dt = 8'd200;
    dones = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.upd_done) dones++;
    end
    bus.req_valid = 1'b0;
    n_checks++; if (dones != 5) $display("FAIL b2b_window_dones: got %0d want 5", dones); else n_pass++;
`ifndef SYN_STDP_STOCHASTIC_EN
    set_w(42, 0);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 7'd42; bus.req_pot = 1'b1; bus.req_dt = 8'd0;
    dones = 0; last = -1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (bus.upd_done) begin dones++; last = c; end
    end
    bus.req_valid = 1'b0;
    n_checks++; if (dones != 2 || last != 13) $display("FAIL b2b_dones: got %0d last=%0d want 2/13", dones, last); else n_pass++;
    repeat (10) @(negedge clk);
    n_checks++; if (get_w(42) != 32) $display("FAIL b2b_ram: got %0d want 32", get_w(42)); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_op();
    int w0, wen_seen;
    set_w(51, 77);
    w0 = wen_total;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 7'd51; bus.req_pot = 1'b1; bus.req_dt = 8'd0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_checks++; if (bus.req_ready !== 1'b1 || bus.mem_en !== 1'b0) $display("FAIL midrst_idle: got ready=%b en=%b want 1/0", bus.req_ready, bus.mem_en); else n_pass++;
    wen_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.mem_wen) wen_seen++;
    end
    n_checks++; if (wen_seen != 0 || wen_total != w0) $display("FAIL midrst_wen: got %0d writes want 0", wen_total - w0); else n_pass++;
    n_checks++; if (get_w(51) != 77) $display("FAIL midrst_ram: got %0d want 77", get_w(51)); else n_pass++;
  endtask

  task automatic test_random();
    int model [128];
    int a, dt, en_old, en_new, en_lat, bad;
    bit pot;
    for (int i = 0; i < 128; i++) begin
      model[i] = int'($urandom_range(0, 255));
      set_w(i, model[i]);
    end
    for (int k = 0; k < 40; k++) begin
      a = int'($urandom_range(0, 127));
      pot = 1'($urandom);
      dt = int'($urandom_range(0, 90));
      if (k % 8 == 0) model[a] = pot ? 250 : 3;
      set_w(a, model[a]);
      if (dt >= 64) begin
        en_old = 0; en_new = 0; en_lat = 1;
      end else begin
        en_old = model[a];
        en_new = ref_new(model[a], pot, dt);
        en_lat = (en_new == en_old) ? 5 : 6;
        model[a] = en_new;
      end
      issue(a, pot, dt, lat, rdc, wrc, enc, wd, wa, uo, un, lf);
      n_checks++;
      if (uo != en_old || un != en_new || lat != en_lat)
        $display("FAIL rand_%0d: got old=%0d new=%0d lat=%0d want %0d/%0d/%0d (a=%0d pot=%0b dt=%0d)",
                 k, uo, un, lat, en_old, en_new, en_lat, a, pot, dt);
      else n_pass++;
    end
    bad = 0;
    for (int i = 0; i < 128; i++) if (get_w(i) != model[i]) bad++;
    n_checks++; if (bad != 0) $display("FAIL rand_ram: got %0d wrong bytes want 0", bad); else n_pass++;
    n_checks++; if (both_strobes != 0) $display("FAIL ren_wen_overlap: got %0d cycles want 0", both_strobes); else n_pass++;
  endtask

`ifdef SYN_STDP_STOCHASTIC_EN
  task automatic test_stochastic();
    int model [128];
    int a, en_new, writes, exp_writes, w0, bad;
    for (int i = 0; i < 128; i++) begin model[i] = 0; set_w(i, 0); end
    w0 = wen_total; exp_writes = 0; bad = 0;
    for (int k = 0; k < 1000; k++) begin
      a = int'($urandom_range(0, 127));
      issue(a, 1'b1, 0, lat, rdc, wrc, enc, wd, wa, uo, un, lf);
      en_new = (lf[7:0] < 8'd128) ? ((model[a] + 16 > 255) ? 255 : model[a] + 16) : model[a];
      if (en_new != model[a]) exp_writes++;
      model[a] = en_new;
      if (un != en_new || lat < 0) bad++;
    end
    writes = wen_total - w0;
    n_checks++; if (bad != 0) $display("FAIL stoch_upd: got %0d mismatching requests want 0", bad); else n_pass++;
    n_checks++; if (writes != exp_writes) $display("FAIL stoch_writes: got %0d want %0d", writes, exp_writes); else n_pass++;
    n_checks++; if (writes < 450 || writes > 550) $display("FAIL stoch_range: got %0d want 450..550", writes); else n_pass++;
  endtask
`endif

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at 1ms, required finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = 32'h0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_pot   = 1'b0;
    bus.req_dt    = '0;
    test_reset();
`ifndef SYN_STDP_STOCHASTIC_EN
    test_basic();
    test_saturation();
`endif
    test_window();
    test_back_to_back();
    test_reset_mid_op();
`ifndef SYN_STDP_STOCHASTIC_EN
    test_random();
`else
    test_stochastic();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
